// File: rtl/conv_encoder_puncturer_pkg.sv
// Shared constants and puncture-table helpers for the K=7 convolutional encoder/puncturer.
package conv_encoder_puncturer_pkg;

  localparam logic [1:0] RATE_1_2 = 2'b00;
  localparam logic [1:0] RATE_2_3 = 2'b01;
  localparam logic [1:0] RATE_3_4 = 2'b10;

  // Bit 6 multiplies the incoming bit, bit 5 the newest delay stage, bit 0 the oldest.
  localparam logic [6:0] G0 = 7'b1011011;
  localparam logic [6:0] G1 = 7'b1111001;

  localparam int TAIL_LEN = 6;

  typedef enum logic [1:0] {
    KEEP_AB,
    KEEP_A,
    KEEP_B
  } keep_e;

  function automatic keep_e puncture(input logic [1:0] rate, input logic [1:0] phase);
    keep_e k;
    k = KEEP_AB;
    if ((rate == RATE_2_3) && (phase == 2'd1)) k = KEEP_A;
    if ((rate == RATE_3_4) && (phase == 2'd1)) k = KEEP_A;
    if ((rate == RATE_3_4) && (phase == 2'd2)) k = KEEP_B;
    return k;
  endfunction

  // Rate code 11 falls into the default arm and behaves as rate 1/2.
  function automatic logic [1:0] advance_phase(input logic [1:0] rate, input logic [1:0] phase);
    logic [1:0] p;
    case (rate)
      RATE_2_3: p = (phase == 2'd1) ? 2'd0 : 2'd1;
      RATE_3_4: p = (phase == 2'd2) ? 2'd0 : phase + 2'd1;
      default:  p = 2'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/conv_encoder_puncturer_core.sv
// Mother-code core: 6-stage shift register and the two generator parities, with frame-start clear.
module conv_enc_core
  import conv_encoder_puncturer_pkg::*;
#(
  parameter int K = 7
) (
  input  logic clk,
  input  logic reset_n,
  input  logic fire,
  input  logic data,
  input  logic start,
  output logic a,
  output logic b
);

  logic [K-2:0] sreg_q;
  logic [K-2:0] sreg_d;
  logic [K-2:0] state;

  // A start bit is encoded as if the register already held zeros.
  assign state = start ? '0 : sreg_q;
  assign a     = ^({data, state} & G0);
  assign b     = ^({data, state} & G1);

  always_comb begin
    sreg_d = sreg_q;
    if (fire) sreg_d = {data, state[K-2:1]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) sreg_q <= '0;
    else          sreg_q <= sreg_d;
  end

endmodule

// File: rtl/conv_encoder_puncturer.sv
// Convolutional encoder + puncturer (rates 1/2, 2/3, 3/4) with valid/ready on both sides.
// Define CONVENC_AUTO_TAIL_EN to append six internally generated zero tail bits after In_Last.
module conv_encoder_puncturer
  import conv_encoder_puncturer_pkg::*;
#(
  parameter int RATE_W = 2,
  parameter int K      = 7
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Data,
  input  logic              In_Valid,
  input  logic              In_Start,
  input  logic              In_Last,
  input  logic [RATE_W-1:0] Rate,
  output logic              In_Ready,
  output logic              Out,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic              Out_Last
);

  logic       room, in_fire, out_fire;
  logic       enc_fire, enc_data, enc_start, enc_last;
  logic       enc_a, enc_b;
  logic [1:0] rate_q, rate_d, phase_q, phase_d;
  logic [1:0] cnt_q, cnt_d, buf_q, buf_d, last_q, last_d;
  logic [1:0] use_rate, use_phase;
  keep_e      keep;

  // A new symbol may load when the buffer is empty or its final bit leaves this cycle.
  assign room     = (cnt_q == 2'd0) | ((cnt_q == 2'd1) & Out_Ready);
  assign out_fire = Out_Valid & Out_Ready;

`ifdef CONVENC_AUTO_TAIL_EN
  logic [2:0] tail_q, tail_d;

  assign In_Ready  = room & (tail_q == 3'd0);
  assign in_fire   = In_Valid & In_Ready;
  assign enc_fire  = in_fire | (room & (tail_q != 3'd0));
  assign enc_data  = in_fire & Data;
  assign enc_start = in_fire & In_Start;
  assign enc_last  = (tail_q == 3'd1);

  always_comb begin
    tail_d = tail_q;
    if (in_fire && In_Last)             tail_d = 3'(TAIL_LEN);
    else if (enc_fire && tail_q != 3'd0) tail_d = tail_q - 3'd1;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) tail_q <= 3'd0;
    else        tail_q <= tail_d;
  end
`else
  assign In_Ready  = room;
  assign in_fire   = In_Valid & In_Ready;
  assign enc_fire  = in_fire;
  assign enc_data  = Data;
  assign enc_start = in_fire & In_Start;
  assign enc_last  = In_Last;
`endif

  conv_enc_core #(.K(K)) u_core (
    .clk     (Clk),
    .reset_n (Reset),
    .fire    (enc_fire),
    .data    (enc_data),
    .start   (enc_start),
    .a       (enc_a),
    .b       (enc_b)
  );

  // Buffer slot 0 is the head; a load replaces whatever the shift would leave.
  always_comb begin
    use_rate  = enc_start ? Rate : rate_q;
    use_phase = enc_start ? 2'd0 : phase_q;
    keep      = puncture(use_rate, use_phase);
    rate_d    = rate_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    last_d    = last_q;
    if (out_fire) begin
      buf_d  = {1'b0, buf_q[1]};
      last_d = {1'b0, last_q[1]};
      cnt_d  = cnt_q - 2'd1;
    end
    if (enc_fire) begin
      rate_d  = use_rate;
      phase_d = advance_phase(use_rate, use_phase);
      case (keep)
        KEEP_A: begin
          buf_d  = {1'b0, enc_a};
          last_d = {1'b0, enc_last};
          cnt_d  = 2'd1;
        end
        KEEP_B: begin
          buf_d  = {1'b0, enc_b};
          last_d = {1'b0, enc_last};
          cnt_d  = 2'd1;
        end
        default: begin
          buf_d  = {enc_b, enc_a};
          last_d = {enc_last, 1'b0};
          cnt_d  = 2'd2;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      rate_q  <= 2'b00;
      phase_q <= 2'd0;
      cnt_q   <= 2'd0;
      buf_q   <= 2'b00;
      last_q  <= 2'b00;
    end else begin
      rate_q  <= rate_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      last_q  <= last_d;
    end
  end

  assign Out       = buf_q[0];
  assign Out_Valid = (cnt_q != 2'd0);
  assign Out_Last  = last_q[0];

endmodule

// File: tb/tb_conv_encoder_puncturer.sv
// Scoreboard bench for conv_encoder_puncturer: golden encoder/puncture model feeds an expected queue.
module tb_conv_encoder_puncturer;

  typedef struct packed {
    logic       d;
    logic       st;
    logic       ls;
    logic [1:0] r;
  } stim_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Data = 1'b0;
  logic       In_Valid = 1'b0;
  logic       In_Start = 1'b0;
  logic       In_Last = 1'b0;
  logic [1:0] Rate = 2'b00;
  logic       Out_Ready = 1'b0;
  logic       In_Ready, Out, Out_Valid, Out_Last;

  int checks = 0;
  int fails  = 0;

  stim_t      stim_q[$];
  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];
  logic       tr_ir[$];
  logic       tr_ov[$];
  logic       tr_o[$];
  logic       tr_ol[$];
  int         tr_nobs[$];

  logic [5:0] m_sreg;
  logic [1:0] m_phase;
  logic [1:0] m_rate;

  always #5 Clk = ~Clk;

  conv_encoder_puncturer dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Data      (Data),
    .In_Valid  (In_Valid),
    .In_Start  (In_Start),
    .In_Last   (In_Last),
    .Rate      (Rate),
    .In_Ready  (In_Ready),
    .Out       (Out),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out_Last  (Out_Last)
  );

  // Golden model: octal generators 133/171, puncture patterns 1/2, 2/3 = AB|A, 3/4 = AB|A|B.
  task automatic m_encode(input logic x, input logic st, input logic [1:0] r, input logic lf);
    logic [6:0] v;
    logic a, b, ka, kb;
    if (st) begin
      m_sreg  = 6'd0;
      m_phase = 2'd0;
      m_rate  = r;
    end
    v  = {x, m_sreg};
    a  = ^(v & 7'o133);
    b  = ^(v & 7'o171);
    ka = 1'b1;
    kb = 1'b1;
    if (m_rate == 2'b01 && m_phase == 2'd1) kb = 1'b0;
    if (m_rate == 2'b10 && m_phase == 2'd1) kb = 1'b0;
    if (m_rate == 2'b10 && m_phase == 2'd2) ka = 1'b0;
    if (ka) exp_q.push_back({lf & ~kb, a});
    if (kb) exp_q.push_back({lf, b});
    m_sreg = {x, m_sreg[5:1]};
    case (m_rate)
      2'b01:   m_phase = (m_phase == 2'd0) ? 2'd1 : 2'd0;
      2'b10:   m_phase = (m_phase == 2'd2) ? 2'd0 : m_phase + 2'd1;
      default: m_phase = 2'd0;
    endcase
  endtask

  task automatic model_accept(input stim_t s);
`ifdef CONVENC_AUTO_TAIL_EN
    m_encode(s.d, s.st, s.r, 1'b0);
    if (s.ls)
      for (int i = 0; i < 6; i++) m_encode(1'b0, 1'b0, m_rate, (i == 5));
`else
    m_encode(s.d, s.st, s.r, s.ls);
`endif
  endtask

  task automatic add_frame(input logic [1:0] r, input int n, input logic [31:0] bits, input logic with_last);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s.d  = bits[i];
      s.st = (i == 0);
      s.ls = with_last && (i == n - 1);
      s.r  = r;
      stim_q.push_back(s);
    end
  endtask

  task automatic clear_queues();
    stim_q.delete();
    exp_q.delete();
    obs_q.delete();
  endtask

  // Drives stim_q through the handshake and records every accepted output plus a per-cycle trace.
  task automatic applyStimulus(input int stall_start, input int stall_len, input int budget);
    int   cyc;
    int   idle;
    logic rdy;
    cyc  = 0;
    idle = 0;
    tr_ir.delete(); tr_ov.delete(); tr_o.delete(); tr_ol.delete(); tr_nobs.delete();
    while (1) begin
      if (cyc >= budget) begin
        checks++;
        fails++;
        $display("[TB] FAIL drive_timeout: ran %0d cycles, required completion within %0d", cyc, budget);
        break;
      end
      @(negedge Clk);
      rdy = !(cyc >= stall_start && cyc < stall_start + stall_len);
      Out_Ready = rdy;
      #1;
      tr_ir.push_back(In_Ready);
      tr_ov.push_back(Out_Valid);
      tr_o.push_back(Out);
      tr_ol.push_back(Out_Last);
      tr_nobs.push_back(obs_q.size());
      if (Out_Valid && rdy) obs_q.push_back({Out_Last, Out});
      if (stim_q.size() > 0) begin
        In_Valid = 1'b1;
        Data     = stim_q[0].d;
        In_Start = stim_q[0].st;
        In_Last  = stim_q[0].ls;
        Rate     = stim_q[0].r;
        if (In_Ready) begin
          model_accept(stim_q[0]);
          void'(stim_q.pop_front());
        end
      end else begin
        In_Valid = 1'b0;
        In_Start = 1'b0;
        In_Last  = 1'b0;
        Data     = 1'b0;
      end
      idle = (stim_q.size() == 0 && !Out_Valid) ? idle + 1 : 0;
      cyc++;
      if (idle >= 3) break;
    end
    In_Valid = 1'b0;
    In_Start = 1'b0;
    In_Last  = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    Out_Ready = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checks++; if (Out_Valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b required 0", Out_Valid); end
    checks++; if (Out !== 1'b0)       begin fails++; $display("[TB] FAIL reset_out: got %b required 0", Out); end
    checks++; if (Out_Last !== 1'b0)  begin fails++; $display("[TB] FAIL reset_out_last: got %b required 0", Out_Last); end
    checks++; if (In_Ready !== 1'b1)  begin fails++; $display("[TB] FAIL reset_in_ready: got %b required 1", In_Ready); end
    Reset = 1'b1;
  endtask

  task automatic test_impulse(input logic [1:0] r, input int n_in, input string golden);
    logic [1:0] o, e;
    int n;
    clear_queues();
    add_frame(r, n_in, 32'd1, 1'b0);
    applyStimulus(1000, 0, 200);
    n = golden.len();
    checks++;
    if (obs_q.size() != n) begin
      fails++;
      $display("[TB] FAIL impulse_r%0d_count: got %0d coded bits required %0d", r, obs_q.size(), n);
    end
    for (int i = 0; i < n && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== {1'b0, golden[i] == "1"}) begin
        fails++;
        $display("[TB] FAIL impulse_r%0d_bit%0d: got last/bit %b required %b", r, i, obs_q[i], {1'b0, golden[i] == "1"});
      end
    end
    if (r == 2'b00) begin
      for (int c = 0; c < 14 && c < tr_ir.size(); c++) begin
        checks++;
        if (tr_ir[c] !== ((c % 2) == 0)) begin
          fails++;
          $display("[TB] FAIL impulse_in_ready_c%0d: got %b required %b", c, tr_ir[c], (c % 2) == 0);
        end
      end
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
      checks++;
      if (o !== e) begin fails++; $display("[TB] FAIL impulse_r%0d_scoreboard: got %b required %b", r, o, e); end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] o, e;
    int idx;
    clear_queues();
    add_frame(2'b01, 12, 32'hB2D, 1'b0);
    applyStimulus(4, 5, 300);
    for (int c = 4; c < 9 && c < tr_ov.size(); c++) begin
      idx = tr_nobs[c];
      checks++;
      if (tr_ov[c] !== 1'b1) begin fails++; $display("[TB] FAIL stall_out_valid_c%0d: got %b required 1", c, tr_ov[c]); end
      checks++;
      if (tr_ir[c] !== 1'b0) begin fails++; $display("[TB] FAIL stall_in_ready_c%0d: got %b required 0", c, tr_ir[c]); end
      if (idx < exp_q.size()) begin
        checks++;
        if ({tr_ol[c], tr_o[c]} !== exp_q[idx]) begin
          fails++;
          $display("[TB] FAIL stall_out_c%0d: got %b required %b", c, {tr_ol[c], tr_o[c]}, exp_q[idx]);
        end
      end
    end
    checks++;
    if (obs_q.size() != 18) begin fails++; $display("[TB] FAIL stall_count: got %0d required 18", obs_q.size()); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
      checks++;
      if (o !== e) begin fails++; $display("[TB] FAIL stall_scoreboard: got %b required %b", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] o, e;
    int lasts, n_req;
    clear_queues();
    add_frame(2'b00, 5, 32'h1D, 1'b1);
    add_frame(2'b10, 6, 32'h2B, 1'b1);
`ifdef CONVENC_AUTO_TAIL_EN
    n_req = 38;
`else
    n_req = 18;
`endif
    applyStimulus(1000, 0, 400);
    lasts = 0;
    foreach (obs_q[i]) lasts += int'(obs_q[i][1]);
    checks++;
    if (obs_q.size() != n_req) begin fails++; $display("[TB] FAIL b2b_count: got %0d required %0d", obs_q.size(), n_req); end
    checks++;
    if (lasts != 2) begin fails++; $display("[TB] FAIL b2b_last_count: got %0d required 2", lasts); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
      checks++;
      if (o !== e) begin fails++; $display("[TB] FAIL b2b_scoreboard: got %b required %b", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] o, e;
    int n_req;
    clear_queues();
    @(negedge Clk);
    Out_Ready = 1'b1;
    In_Valid  = 1'b1;
    Data      = 1'b1;
    In_Start  = 1'b1;
    In_Last   = 1'b0;
    Rate      = 2'b00;
    @(negedge Clk);
    In_Valid = 1'b0;
    In_Start = 1'b0;
    checks++;
    if (Out_Valid !== 1'b1) begin fails++; $display("[TB] FAIL midreset_preload: got out_valid %b required 1", Out_Valid); end
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    checks++; if (Out_Valid !== 1'b0) begin fails++; $display("[TB] FAIL midreset_out_valid: got %b required 0", Out_Valid); end
    checks++; if (Out !== 1'b0)       begin fails++; $display("[TB] FAIL midreset_out: got %b required 0", Out); end
    checks++; if (In_Ready !== 1'b1)  begin fails++; $display("[TB] FAIL midreset_in_ready: got %b required 1", In_Ready); end
    @(negedge Clk);
    checks++; if (Out_Valid !== 1'b0) begin fails++; $display("[TB] FAIL midreset_no_output: got %b required 0", Out_Valid); end
    add_frame(2'b00, 4, 32'hB, 1'b1);
`ifdef CONVENC_AUTO_TAIL_EN
    n_req = 20;
`else
    n_req = 8;
`endif
    applyStimulus(1000, 0, 200);
    checks++;
    if (obs_q.size() != n_req) begin fails++; $display("[TB] FAIL midreset_count: got %0d required %0d", obs_q.size(), n_req); end
    checks++;
    if (obs_q.size() > 1 && obs_q[0] !== 2'b01) begin fails++; $display("[TB] FAIL midreset_first: got %b required 01", obs_q[0]); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
      checks++;
      if (o !== e) begin fails++; $display("[TB] FAIL midreset_scoreboard: got %b required %b", o, e); end
    end
  endtask

  initial begin
    m_sreg  = 6'd0;
    m_phase = 2'd0;
    m_rate  = 2'b00;
    test_reset();
    test_impulse(2'b00, 7, "11011111001011");
    test_impulse(2'b10, 6, "11011100");
    test_impulse(2'b01, 6, "110111001");
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/conv_encoder_puncturer.md
Name: conv_encoder_puncturer

Overview:
- Transmit-chain stage directly downstream of the scrambler.
- Takes the serial scrambled bit stream, applies the 802.11a K=7 convolutional code (g0=133 octal, g1=171 octal), punctures to rate 1/2, 2/3 or 3/4, and emits a serial coded bit stream toward the interleaver.
- Uses valid/ready handshakes on both sides; one bit per transfer.

Parameters:
- RATE_W, 2, width of rate select.
- K, 7, constraint length; shift register is K-1 = 6 bits.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-low reset.
- Data  input  1  scrambled input bit.
- In_Valid  input  1  Data is valid.
- In_Start  input  1  qualifies the first bit of a frame (sampled with In_Valid).
- In_Last  input  1  qualifies the last bit of a frame (sampled with In_Valid).
- Rate  input  2  00=1/2, 01=2/3, 10=3/4, 11=treated as 1/2; latched on a start transfer.
- In_Ready  output  1  block accepts Data this cycle.
- Out  output  1  coded bit.
- Out_Valid  output  1  Out is valid.
- Out_Ready  input  1  downstream accepts Out.
- Out_Last  output  1  marks the final coded bit of a frame.

Behaviour:
- Reset (Reset=0 at a rising edge) clears all state on that edge:
  - sreg=0, phase=0, rate_q=00.
  - Buffer count cnt=0, Out=0, Out_Valid=0, Out_Last=0.
  - In_Ready reads 1 after reset; it is combinational on cnt.
- Reset mid-frame drops all buffered bits; no output is produced after it.
- Transfer: in = In_Valid & In_Ready; out = Out_Valid & Out_Ready.
- Encoder, with x the input bit and d1..d6 the sreg (d1 newest):
  - A = x^d2^d3^d5^d6.
  - B = x^d1^d2^d3^d6.
  - On in: sreg <= {x, d1..d5}.
- On in with In_Start:
  - Encode with sreg treated as 0.
  - Phase is 0 for this bit.
  - rate_q <= Rate; the new rate applies to this bit.
- Puncture table, selected by rate_q and phase. Kept bits load into a 2-bit buffer, with A sent before B.
  - 1/2: phase stays 0; keep A,B.
  - 2/3: phase 0 keeps A,B; phase 1 keeps A; phase cycles 0,1.
  - 3/4: phase 0 keeps A,B; phase 1 keeps A; phase 2 keeps B; phase cycles 0,1,2.
- Phase advances on every in and wraps to 0.
- Out_Valid = (cnt!=0). Out is the head of the buffer, registered, so the first coded bit appears one cycle after in.
- Buffer on out: shift; cnt decrements.
- In_Ready = (cnt==0) | (cnt==1 & Out_Ready).
  - If in and out occur in the same cycle, the load overrides the shift.
  - No bubble: at rate 1/2 the block sustains one output per cycle with one input every 2 cycles.
- While Out_Ready=0: Out, Out_Valid and Out_Last stay stable.
- Out_Last=1 on the last kept bit produced from an In_Last input. When the auto-tail feature is enabled, it instead marks the last kept bit of the tail.
- In_Start and In_Last together mean a single-bit frame; both take effect.

Optional Feature:
- Macro: CONVENC_AUTO_TAIL_EN.
- When defined:
  - After an In_Last transfer, the block internally encodes 6 zero bits through the same puncture path.
  - In_Ready=0 during the tail.
  - Out_Last marks the final kept tail bit.
  - The tail is included in the frame's puncture phase sequence.
- When undefined:
  - Upstream supplies the tail zeros.
  - Out_Last follows the In_Last bit.

Decomposition:
- Header conv_enc_defs.vh holds:
  - Rate codes RATE_1_2, RATE_2_3, RATE_3_4.
  - Generator masks G0=7'b1011011, G1=7'b1111001.
  - Tail length 6.
- Sub-module conv_enc_core holds the 6-bit shift register, A/B generation, and the start-clear. The parent holds phase, puncture, buffer, handshake and tail.

Test Plan:
- Rate 1/2, impulse 1 then six 0s, Out_Ready=1 → Out = 11 01 11 11 00 10 11; In_Ready toggles 1,0.
- Rate 3/4, impulse 1 then five 0s → Out = 1,1,0,1,1,1,0,0; 8 coded bits for 6 inputs.
- Rate 2/3, impulse 1 then five 0s → Out = 1,1,0,1,1,1,0,0,1; 9 coded bits for 6 inputs.
- Backpressure: hold Out_Ready=0 for 5 cycles mid-frame → Out and Out_Valid frozen, In_Ready=0, no bits lost or duplicated against the golden model.
- In_Start with a rate change 1/2→3/4 on back-to-back frames → sreg clears and phase restarts at 0; Out_Last is asserted once per frame (after tail with CONVENC_AUTO_TAIL_EN: 6 extra inputs → 8 extra bits at 3/4).
- Reset=0 for one cycle mid-buffer (cnt=2) → next cycle Out_Valid=0, Out=0, In_Ready=1; a subsequent start encodes from the zero state.
